// File: rtl/render_pkg.sv
// Shared rendering definitions: sequencer state encoding, palette constants
// and the framebuffer linear-address helper.
package render_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_SCAN   = 3'd2;
    localparam state_t ST_LAUNCH = 3'd3;
    localparam state_t ST_DRAW   = 3'd4;
    localparam state_t ST_FINISH = 3'd5;

    localparam logic [3:0] COLOR_BLACK = 4'h0;
    localparam logic [3:0] COLOR_WHITE = 4'hF;

    // Row-major framebuffer address of pixel (h, v).
    function automatic int unsigned pixel_addr(input int unsigned h,
                                               input int unsigned v,
                                               input int unsigned width);
        return h + width * v;
    endfunction

endpackage

// File: rtl/fb_clear_counter.sv
// Linear framebuffer address counter used to sweep every pixel during the
// clear phase; last flags the final address so the sweep ends on time.
module fb_clear_counter #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] count,
    output logic          last
);

    assign last = (count == AW'(DEPTH - 1));

    // NOTE: non-blocking assignment so every flop updates from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Per-frame controller owning the framebuffer write port: clears the frame,
// then walks enabled object slots through one shared polygon drawer.
module frame_draw_sequencer
    import render_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 1280,
    parameter int PIXEL_HEIGHT = 720,
    parameter int MAX_OBJECTS  = 8,
    parameter int DRAW_TIMEOUT = 2000000,
    localparam int IDX_W  = (MAX_OBJECTS > 1) ? $clog2(MAX_OBJECTS) : 1,
    localparam int H_W    = $clog2(PIXEL_WIDTH),
    localparam int V_W    = $clog2(PIXEL_HEIGHT),
    localparam int ADDR_W = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [3:0]             background_color,
    input  logic [MAX_OBJECTS-1:0] obj_enable_in,
    output logic                   draw_start_out,
    output logic [IDX_W-1:0]       draw_idx_out,
    input  logic [H_W-1:0]         draw_hcount_in,
    input  logic [V_W-1:0]         draw_vcount_in,
    input  logic [3:0]             draw_color_in,
    input  logic                   draw_valid_in,
    input  logic                   draw_done_in,
    output logic [ADDR_W-1:0]      fb_addr_out,
    output logic [3:0]             fb_data_out,
    output logic                   fb_we_out,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic                   timeout_out
);

    localparam int NPIX    = PIXEL_WIDTH * PIXEL_HEIGHT;
    localparam int TIMER_W = $clog2(DRAW_TIMEOUT + 1);

    state_t                 state;
    logic [3:0]             bg_q;
    logic [MAX_OBJECTS-1:0] en_q;
    logic [IDX_W-1:0]       ptr;
    logic [TIMER_W-1:0]     timer;
    logic [ADDR_W-1:0]      clr_addr;
    logic                   clr_last;
    logic                   pix_ok;
    logic                   last_slot;
    logic                   timer_expired;

    assign pix_ok = draw_valid_in
                 && (32'(draw_hcount_in) < PIXEL_WIDTH)
                 && (32'(draw_vcount_in) < PIXEL_HEIGHT);
    assign last_slot     = (ptr == IDX_W'(MAX_OBJECTS - 1));
    assign timer_expired = (timer == TIMER_W'(DRAW_TIMEOUT - 1));

    fb_clear_counter #(
        .DEPTH (NPIX),
        .AW    (ADDR_W)
    ) u_clear_counter (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (state == ST_IDLE),
        .advance (state == ST_CLEAR),
        .count   (clr_addr),
        .last    (clr_last)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            bg_q           <= COLOR_BLACK;
            en_q           <= '0;
            ptr            <= '0;
            timer          <= '0;
            draw_start_out <= 1'b0;
            draw_idx_out   <= '0;
            fb_addr_out    <= '0;
            fb_data_out    <= COLOR_BLACK;
            fb_we_out      <= 1'b0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
            timeout_out    <= 1'b0;
        end else begin
            draw_start_out <= 1'b0;
            frame_done_out <= 1'b0;
            fb_we_out      <= 1'b0;
            // busy drops the cycle after the done pulse unless a new frame starts
            if (frame_done_out) busy_out <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        bg_q        <= background_color;
                        en_q        <= obj_enable_in;
                        timeout_out <= 1'b0;
                        busy_out    <= 1'b1;
                        state       <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    fb_we_out   <= 1'b1;
                    fb_addr_out <= clr_addr;
                    fb_data_out <= bg_q;
                    if (clr_last) begin
                        ptr   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (en_q[ptr])      state <= ST_LAUNCH;
                    else if (last_slot) state <= ST_FINISH;
                    else                ptr   <= ptr + 1'b1;
                end
                ST_LAUNCH: begin
                    draw_start_out <= 1'b1;
                    draw_idx_out   <= ptr;
                    timer          <= '0;
                    state          <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (pix_ok) begin
                        fb_we_out   <= 1'b1;
                        fb_addr_out <= ADDR_W'(pixel_addr(32'(draw_hcount_in),
                                                          32'(draw_vcount_in),
                                                          PIXEL_WIDTH));
                        fb_data_out <= draw_color_in;
                    end
                    // A timed-out slot is abandoned exactly as if the drawer finished it.
                    if (draw_done_in || timer_expired) begin
                        if (!draw_done_in) timeout_out <= 1'b1;
                        if (last_slot) begin
                            state <= ST_FINISH;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= ST_SCAN;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_FINISH: begin
                    frame_done_out <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Scoreboard bench for frame_draw_sequencer: a reference model predicts every
// framebuffer write and drawer launch; a monitor compares as the DUT emits them.
module tb_frame_draw_sequencer;

    localparam int W  = 6;
    localparam int H  = 3;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int HW = $clog2(W);
    localparam int VW = $clog2(H);
    localparam int AW = $clog2(W * H);
    localparam int IW = $clog2(N);

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic [3:0]    background_color = '0;
    logic [N-1:0]  obj_enable_in = '0;
    logic          draw_start_out;
    logic [IW-1:0] draw_idx_out;
    logic [HW-1:0] draw_hcount_in = '0;
    logic [VW-1:0] draw_vcount_in = '0;
    logic [3:0]    draw_color_in = '0;
    logic          draw_valid_in = 1'b0;
    logic          draw_done_in = 1'b0;
    logic [AW-1:0] fb_addr_out;
    logic [3:0]    fb_data_out;
    logic          fb_we_out;
    logic          busy_out;
    logic          frame_done_out;
    logic          timeout_out;

    frame_draw_sequencer #(
        .PIXEL_WIDTH  (W),
        .PIXEL_HEIGHT (H),
        .MAX_OBJECTS  (N),
        .DRAW_TIMEOUT (TO)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .background_color (background_color),
        .obj_enable_in    (obj_enable_in),
        .draw_start_out   (draw_start_out),
        .draw_idx_out     (draw_idx_out),
        .draw_hcount_in   (draw_hcount_in),
        .draw_vcount_in   (draw_vcount_in),
        .draw_color_in    (draw_color_in),
        .draw_valid_in    (draw_valid_in),
        .draw_done_in     (draw_done_in),
        .fb_addr_out      (fb_addr_out),
        .fb_data_out      (fb_data_out),
        .fb_we_out        (fb_we_out),
        .busy_out         (busy_out),
        .frame_done_out   (frame_done_out),
        .timeout_out      (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { int h; int v; int c; } pix_t;
    typedef struct { int addr; int data; } wr_t;

    pix_t slot_px[N][$];
    wr_t  exp_wr[$];
    int   exp_idx[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   frames_exp = 0;
    bit   mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or launches.
    always @(negedge clk_in) begin : monitor
        wr_t w;
        int  ix;
        if (frame_done_out) done_cnt++;
        if (mon_on) begin
            if (fb_we_out) begin
                if (exp_wr.size() == 0) flag_fail("fb_write_unexpected");
                else begin
                    w = exp_wr.pop_front();
                    check("fb_addr", 32'(fb_addr_out), w.addr);
                    check("fb_data", 32'(fb_data_out), w.data);
                end
            end
            if (draw_start_out) begin
                if (exp_idx.size() == 0) flag_fail("launch_unexpected");
                else begin
                    ix = exp_idx.pop_front();
                    check("draw_idx", 32'(draw_idx_out), ix);
                end
            end
        end
    end

    task automatic gen_pixels(input int min_n);
        pix_t p;
        for (int s = 0; s < N; s++) begin
            slot_px[s].delete();
            for (int i = 0; i < $urandom_range(min_n, 4); i++) begin
                p.h = $urandom_range(0, 7);
                p.v = $urandom_range(0, 3);
                p.c = $urandom_range(0, 15);
                slot_px[s].push_back(p);
            end
        end
    endtask

    // Behavioural drawer: replays the scripted pixel list for the launched slot.
    task automatic run_slot(input int idx, input int hang, input bit mid_start);
        int c;
        int np;
        bit co;
        if (idx == hang) begin
            c = 0;
            while (!timeout_out && c < 100) begin
                @(negedge clk_in);
                c++;
            end
            check("timeout_latency", c, TO);
            return;
        end
        np = slot_px[idx].size();
        co = 1'($urandom_range(0, 1));
        for (int i = 0; i < np; i++) begin
            @(posedge clk_in); #1;
            draw_valid_in  = 1'b1;
            draw_hcount_in = HW'(slot_px[idx][i].h);
            draw_vcount_in = VW'(slot_px[idx][i].v);
            draw_color_in  = 4'(slot_px[idx][i].c);
            draw_done_in   = co && (i == np - 1);
            start_in       = mid_start && (i == 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_in); #1;
                draw_valid_in = 1'b0;
                draw_done_in  = 1'b0;
                start_in      = 1'b0;
            end
        end
        if (!co || np == 0) begin
            @(posedge clk_in); #1;
            draw_valid_in = 1'b0;
            draw_done_in  = 1'b1;
            start_in      = 1'b0;
        end
        @(posedge clk_in); #1;
        draw_valid_in = 1'b0;
        draw_done_in  = 1'b0;
        start_in      = 1'b0;
    endtask

    task automatic run_frame(input int bg, input int en, input int hang,
                             input bit mid_start, input int exp_cycles);
        wr_t w;
        int  cyc;
        bit  got_done;
        bit  exp_to;
        exp_wr.delete();
        exp_idx.delete();
        for (int a = 0; a < W * H; a++) begin
            w.addr = a;
            w.data = bg;
            exp_wr.push_back(w);
        end
        exp_to = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (((en >> s) & 1) == 1) begin
                exp_idx.push_back(s);
                if (s == hang) exp_to = 1'b1;
                else begin
                    for (int i = 0; i < slot_px[s].size(); i++) begin
                        if (slot_px[s][i].h < W && slot_px[s][i].v < H) begin
                            w.addr = slot_px[s][i].h + W * slot_px[s][i].v;
                            w.data = slot_px[s][i].c;
                            exp_wr.push_back(w);
                        end
                    end
                end
            end
        end
        frames_exp++;

        @(posedge clk_in); #1;
        background_color = 4'(bg);
        obj_enable_in    = N'(en);
        start_in         = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;

        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) begin
                check("busy_after_start", 32'(busy_out), 1);
                check("timeout_cleared", 32'(timeout_out), 0);
            end
            if (mid_start && cyc == 4) begin
                start_in         = 1'b1;
                background_color = ~4'(bg);
                obj_enable_in    = ~N'(en);
                draw_valid_in    = 1'b1;
                draw_hcount_in   = '0;
                draw_vcount_in   = '0;
                draw_color_in    = 4'hF;
                draw_done_in     = 1'b1;
            end
            if (mid_start && cyc == 5) begin
                start_in      = 1'b0;
                draw_valid_in = 1'b0;
                draw_done_in  = 1'b0;
            end
            if (frame_done_out) got_done = 1'b1;
            else if (draw_start_out) run_slot(int'(draw_idx_out), hang, mid_start);
        end
        check("frame_done_seen", 32'(got_done), 1);
        if (exp_cycles >= 0) check("frame_cycles", cyc, exp_cycles);
        check("busy_at_done", 32'(busy_out), 1);
        check("timeout_flag", 32'(timeout_out), 32'(exp_to));
        @(negedge clk_in);
        check("busy_after_done", 32'(busy_out), 0);
        repeat (4) @(negedge clk_in);
        check("writes_pending", exp_wr.size(), 0);
        check("launches_pending", exp_idx.size(), 0);
        check("done_count", done_cnt, frames_exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fb_we"}, 32'(fb_we_out), 0);
        check({tag, "_fb_addr"}, 32'(fb_addr_out), 0);
        check({tag, "_fb_data"}, 32'(fb_data_out), 0);
        check({tag, "_busy"}, 32'(busy_out), 0);
        check({tag, "_frame_done"}, 32'(frame_done_out), 0);
        check({tag, "_timeout"}, 32'(timeout_out), 0);
        check({tag, "_draw_start"}, 32'(draw_start_out), 0);
        check({tag, "_draw_idx"}, 32'(draw_idx_out), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench did not complete");
    end

    initial begin : main
        pix_t p;
        int   seen;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_all_zero("reset");
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        mon_on = 1'b1;

        // Empty frame: clear sweep, N scan cycles, finish.
        gen_pixels(0);
        run_frame(2, 0, -1, 1'b0, W * H + N + 2);

        // Directed slots 0 and 2, with out-of-range pixels followed by a valid one.
        for (int s = 0; s < N; s++) slot_px[s].delete();
        p = '{h: 1, v: 1, c: 3}; slot_px[0].push_back(p);
        p = '{h: 5, v: 2, c: 3}; slot_px[0].push_back(p);
        p = '{h: 6, v: 0, c: 7}; slot_px[2].push_back(p);
        p = '{h: 0, v: 3, c: 7}; slot_px[2].push_back(p);
        p = '{h: 5, v: 2, c: 3}; slot_px[2].push_back(p);
        p = '{h: 7, v: 3, c: 1}; slot_px[2].push_back(p);
        p = '{h: 1, v: 1, c: 3}; slot_px[2].push_back(p);
        run_frame(5, 4'b0101, -1, 1'b0, -1);

        // Slot 1 never completes and must time out; slot 2 still runs.
        gen_pixels(1);
        run_frame(1, 4'b0110, 1, 1'b0, -1);

        // Stray start pulses and drawer strobes during CLEAR, start during DRAW.
        gen_pixels(1);
        run_frame(9, 4'b0011, -1, 1'b1, -1);

        // Reset in the middle of DRAW.
        gen_pixels(1);
        mon_on = 1'b0;
        @(posedge clk_in); #1;
        background_color = 4'd3;
        obj_enable_in    = 4'b0010;
        start_in         = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk_in);
            if (draw_start_out) seen = 1;
        end
        check("rst_launch_seen", seen, 1);
        @(posedge clk_in); #1;
        draw_valid_in  = 1'b1;
        draw_hcount_in = 3'd1;
        draw_vcount_in = 2'd1;
        draw_color_in  = 4'd4;
        rst_in         = 1'b1;
        @(posedge clk_in); #1;
        rst_in        = 1'b0;
        draw_valid_in = 1'b0;
        @(negedge clk_in);
        check_all_zero("mid_reset");
        exp_wr.delete();
        exp_idx.delete();
        #1 mon_on = 1'b1;
        repeat (30) @(negedge clk_in);
        check("no_done_after_reset", done_cnt, frames_exp);
        run_frame(6, 4'b1010, -1, 1'b0, -1);

        // Randomised frames.
        for (int f = 0; f < 6; f++) begin
            int hang;
            gen_pixels(0);
            hang = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            run_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), hang, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
